// File: rtl/pipeline_stage_sequencer_pkg.sv
// pipeline_stage_sequencer_pkg: stage/type/group codes and MEM-length helpers shared by the sequencer
package pipeline_stage_sequencer_pkg;
  localparam int STAGE_W = 3;
  localparam int TYPE_W = 4;
  localparam int GROUP_W = 4;
  localparam int SEQ_MEM_CYCLES_MAX = 2;
  localparam int MEM_CYC_W = $clog2(SEQ_MEM_CYCLES_MAX + 1);
  typedef enum logic [STAGE_W-1:0] {
    STAGE_IF  = 3'd0,
    STAGE_ID  = 3'd1,
    STAGE_EX  = 3'd2,
    STAGE_MEM = 3'd3,
    STAGE_WB  = 3'd4
  } stage_e;
  typedef enum logic [TYPE_W-1:0] {
    TYPE_NOP   = 4'd0,
    TYPE_ADD   = 4'd1,
    TYPE_LD    = 4'd2,
    TYPE_ST    = 4'd3,
    TYPE_PUSH  = 4'd4,
    TYPE_POP   = 4'd5,
    TYPE_RCALL = 4'd6,
    TYPE_RET   = 4'd7,
    TYPE_RJMP  = 4'd8
  } type_e;
  localparam int GROUP_ALU   = 0;
  localparam int GROUP_LOAD  = 1;
  localparam int GROUP_STORE = 2;
  localparam int GROUP_STACK = 3;
  localparam logic [GROUP_W-1:0] GROUP_MEM_MASK =
    GROUP_W'((1 << GROUP_LOAD) | (1 << GROUP_STORE) | (1 << GROUP_STACK));
  // RCALL/RET move a 2-byte PC through data memory
  function automatic logic is_two_byte(input logic [TYPE_W-1:0] t);
    return t == TYPE_RCALL || t == TYPE_RET;
  endfunction
endpackage

// File: rtl/pipeline_stage_sequencer_mem_cycle_calc.sv
// pipeline_stage_sequencer_mem_cycle_calc: decoded opcode -> MEM sub-cycle count and MEM-needed flag
module pipeline_stage_sequencer_mem_cycle_calc
  import pipeline_stage_sequencer_pkg::*;
(
  input  logic [TYPE_W-1:0]    opcode_type_i,
  input  logic [GROUP_W-1:0]   opcode_group_i,
  output logic [MEM_CYC_W-1:0] mem_cycles_o,
  output logic                 needs_mem_o
);
  assign mem_cycles_o = is_two_byte(opcode_type_i) ? MEM_CYC_W'(2) : MEM_CYC_W'(1);
  assign needs_mem_o  = is_two_byte(opcode_type_i) || |(opcode_group_i & GROUP_MEM_MASK);
endmodule

// File: rtl/pipeline_stage_sequencer.sv
// pipeline_stage_sequencer: IF->ID->EX->MEM->WB stepper with MEM hold, strobes and retire counter (SEQ_MEM_SKIP_EN lets non-memory instructions bypass MEM)
module pipeline_stage_sequencer
  import pipeline_stage_sequencer_pkg::*;
#(
  parameter int RETIRE_CNT_W = 16,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    halt,
  input  logic                    mem_wait,
  input  logic [TYPE_W-1:0]       opcode_type,
  input  logic [GROUP_W-1:0]      opcode_group,
  output logic [STAGE_W-1:0]      pipeline_stage,
  output logic                    cycle_count,
  output logic                    fetch_en,
  output logic                    instr_done,
  output logic [RETIRE_CNT_W-1:0] retired_count,
  output logic                    timeout_err
);
  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  stage_e                  stage_q, stage_d;
  logic                    cc_q, cc_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [RETIRE_CNT_W-1:0] ret_q, ret_d;
  logic                    tmo_q, tmo_d;
  logic [MEM_CYC_W-1:0]    mem_cycles;
  logic                    needs_mem;
  logic                    skip_mem;
  logic                    stalled;
  logic                    last_sub;
  pipeline_stage_sequencer_mem_cycle_calc u_calc (
    .opcode_type_i (opcode_type),
    .opcode_group_i(opcode_group),
    .mem_cycles_o  (mem_cycles),
    .needs_mem_o   (needs_mem)
  );
`ifdef SEQ_MEM_SKIP_EN
  assign skip_mem = !needs_mem;
`else
  logic unused_needs_mem;
  assign unused_needs_mem = needs_mem;
  assign skip_mem = 1'b0;
`endif
  // a wait is honoured only until the counter saturates; then the sub-cycle is forced through
  assign stalled  = mem_wait && wait_q != WAIT_W'(MEM_WAIT_MAX);
  assign last_sub = MEM_CYC_W'(cc_q) == mem_cycles - MEM_CYC_W'(1);
  // next-state: stage advance, MEM sub-cycle/wait tracking, retire count; halt freezes all
  always_comb begin
    stage_d = stage_q;
    cc_d    = cc_q;
    wait_d  = wait_q;
    ret_d   = ret_q;
    tmo_d   = tmo_q;
    if (!halt) begin
      case (stage_q)
        STAGE_IF: stage_d = STAGE_ID;
        STAGE_ID: stage_d = STAGE_EX;
        STAGE_EX: stage_d = skip_mem ? STAGE_WB : STAGE_MEM;
        STAGE_MEM: begin
          if (stalled) begin
            wait_d = wait_q + WAIT_W'(1);
          end else begin
            wait_d  = '0;
            tmo_d   = tmo_q | mem_wait;
            cc_d    = !last_sub;
            stage_d = last_sub ? STAGE_WB : STAGE_MEM;
          end
        end
        STAGE_WB: begin
          stage_d = STAGE_IF;
          ret_d   = ret_q + RETIRE_CNT_W'(1);
        end
        default: stage_d = STAGE_IF;
      endcase
    end
  end
  // state registers; reset abandons any in-flight instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= STAGE_IF;
      cc_q    <= 1'b0;
      wait_q  <= '0;
      ret_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      stage_q <= stage_d;
      cc_q    <= cc_d;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
      tmo_q   <= tmo_d;
    end
  end
  assign pipeline_stage = stage_q;
  assign cycle_count    = cc_q;
  assign fetch_en       = stage_q == STAGE_IF && !halt;
  assign instr_done     = stage_q == STAGE_WB && !halt;
  assign retired_count  = ret_q;
  assign timeout_err    = tmo_q;
endmodule
